// File: rtl/vga_sync_tracker.sv
// Receive-side raster tracker for 640x480 VGA timing.
// Rebuilds hpos/vpos from the active-low hsync/vsync inputs.
// Checks sync edges against the expected raster and reports horizontal and vertical lock.
module vga_sync_tracker #(
    parameter int H_ADDR      = 640,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC_LOAD = 658,
    parameter int V_ADDR      = 480,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC_LOAD = 490,
    parameter int LOCK_LINES  = 4,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       display_on,
    output logic       h_locked,
    output logic       v_locked,
    output logic       frame_start
);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_LOAD   = 10'(H_SYNC_LOAD);
    localparam logic [9:0] H_PRE    = 10'(H_SYNC_LOAD - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ADDR);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_LOAD   = 10'(V_SYNC_LOAD);
    localparam logic [9:0] V_ACT    = 10'(V_ADDR);
    localparam logic [9:0] H_LOCK_N = 10'(LOCK_LINES);
    localparam logic [9:0] V_LOCK_N = 10'(LOCK_FRAMES);

    logic       hs_q;
    logic       vs_q;
    logic       hfall;
    logic       vfall;
    logic       h_wrap;
    logic       line_step;
    logic       locked;
    logic [9:0] hpos_next;
    logic [9:0] vpos_next;
    logic       h_match;
    logic       h_bad;
    logic       v_match;
    logic       v_bad;
    logic       vmiss;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [9:0] h_cnt_next;
    logic [9:0] v_cnt_next;

    // Falling-edge detection on the sampled syncs, plus the natural end-of-line step.
    always_comb begin
        hfall     = hs_q & ~hsync;
        vfall     = vs_q & ~vsync;
        h_wrap    = (hpos == H_LAST);
        line_step = h_wrap & ~hfall;
        locked    = h_locked & v_locked;
    end

    // Next raster position: sync edges snap the counters, otherwise free-run.
    always_comb begin
        hpos_next = hpos + 10'd1;
        if (hfall) begin
            hpos_next = H_LOAD;
        end else if (h_wrap) begin
            hpos_next = 10'd0;
        end

        vpos_next = vpos;
        if (vfall) begin
            vpos_next = V_LOAD;
        end else if (line_step) begin
            vpos_next = (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
        end
    end

    // Classify sync timing as a match, or as a mismatch/miss that breaks lock.
    always_comb begin
        h_match = hfall & (hpos == H_PRE);
        h_bad   = hfall ? (hpos != H_PRE) : (hpos == H_PRE);
        v_match = vfall & (vpos == V_LOAD);
        v_bad   = (vfall & (vpos != V_LOAD))
                | (~vfall & line_step & (vpos == V_LOAD) & vmiss);

        h_cnt_next = h_cnt;
        if (h_bad) begin
            h_cnt_next = 10'd0;
        end else if (h_match && (h_cnt != H_LOCK_N)) begin
            h_cnt_next = h_cnt + 10'd1;
        end

        v_cnt_next = v_cnt;
        if (v_bad) begin
            v_cnt_next = 10'd0;
        end else if (v_match && (v_cnt != V_LOCK_N)) begin
            v_cnt_next = v_cnt + 10'd1;
        end
    end

    // Sync sampling and raster position registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_q <= 1'b0;
            vs_q <= 1'b0;
            hpos <= 10'd0;
            vpos <= 10'd0;
        end else begin
            hs_q <= hsync;
            vs_q <= vsync;
            hpos <= hpos_next;
            vpos <= vpos_next;
        end
    end

    // Horizontal lock tracking: consecutive matching lines raise h_locked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt    <= 10'd0;
            h_locked <= 1'b0;
        end else begin
            h_cnt <= h_cnt_next;
            if (h_bad) begin
                h_locked <= 1'b0;
            end else if (h_match && (h_cnt_next == H_LOCK_N)) begin
                h_locked <= 1'b1;
            end
        end
    end

    // Vertical lock tracking. vmiss arms when the sync line is reached by counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_cnt    <= 10'd0;
            v_locked <= 1'b0;
            vmiss    <= 1'b0;
        end else begin
            v_cnt <= v_cnt_next;
            if (v_bad) begin
                v_locked <= 1'b0;
            end else if (v_match && (v_cnt_next == V_LOCK_N)) begin
                v_locked <= 1'b1;
            end
            if (vfall) begin
                vmiss <= 1'b0;
            end else if (line_step && (vpos_next == V_LOAD)) begin
                vmiss <= 1'b1;
            end
        end
    end

    // One-cycle pulse when a locked raster returns to the origin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= locked & (hpos_next == 10'd0) & (vpos_next == 10'd0);
        end
    end

    // Visible area gate, valid only while both axes are locked.
    always_comb begin
        display_on = h_locked & v_locked & (hpos < H_ACT) & (vpos < V_ACT);
    end

endmodule

// File: tb/tb_vga_sync_tracker.sv
// Scoreboard bench for vga_sync_tracker on a scaled-down raster.
// A behavioural sync generator feeds the DUT, with optional random perturbation.
// A linear-index reference model pushes expectations that a negedge monitor pops.
module tb_vga_sync_tracker;

    localparam int HT = 40;
    localparam int HA = 32;
    localparam int HL = 35;
    localparam int VT = 16;
    localparam int VA = 12;
    localparam int VL = 13;
    localparam int LL = 4;
    localparam int LF = 2;
    localparam int HS_START = HL - 2;
    localparam int HS_WIDTH = 4;
    localparam int VS_WIDTH = 2;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       reset;
    logic       hsync;
    logic       vsync;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       display_on;
    logic       h_locked;
    logic       v_locked;
    logic       frame_start;

    vga_sync_tracker #(
        .H_ADDR(HA), .H_TOTAL(HT), .H_SYNC_LOAD(HL),
        .V_ADDR(VA), .V_TOTAL(VT), .V_SYNC_LOAD(VL),
        .LOCK_LINES(LL), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
        .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .h_locked(h_locked), .v_locked(v_locked), .frame_start(frame_start)
    );

    // Free-running pixel clock.
    always #5 clk = ~clk;

    typedef struct {
        int hpos;
        int vpos;
        bit disp;
        bit hl;
        bit vl;
        bit fs;
        bit chk_gen;
        int gh;
        int gv;
    } exp_t;

    exp_t sb[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   fs_count = 0;

    // Reference model: one linear pixel index plus sliding windows of check outcomes.
    int m_pix;
    bit m_hsp;
    bit m_vsp;
    bit m_armed;
    bit hwin[$];
    bit vwin[$];

    // Generator state (positions visible during the current period).
    int gh;
    int gv;
    int line_mode;
    int frame_mode;
    bit hs_out;
    bit vs_out;
    int hold_low;
    bit r_cur;
    bit g_cur;

    function automatic bit h_ok();
        if (hwin.size() < LL) return 1'b0;
        foreach (hwin[i]) if (!hwin[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit v_ok();
        if (vwin.size() < LF) return 1'b0;
        foreach (vwin[i]) if (!vwin[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_h(input bit b);
        hwin.push_back(b);
        if (hwin.size() > LL) hwin.delete(0);
    endtask

    task automatic push_v(input bit b);
        vwin.push_back(b);
        if (vwin.size() > LF) vwin.delete(0);
    endtask

    task automatic model_reset();
        m_pix   = 0;
        m_hsp   = 1'b0;
        m_vsp   = 1'b0;
        m_armed = 1'b0;
        hwin.delete();
        vwin.delete();
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.hpos = 0; e.vpos = 0; e.disp = 0; e.hl = 0; e.vl = 0; e.fs = 0;
        e.chk_gen = 0; e.gh = 0; e.gv = 0;
        return e;
    endfunction

    task automatic model_step(input bit hs, input bit vs, output exp_t e);
        bit hfall, vfall, advance, was_locked;
        int h, v, nh, nv, p;
        hfall = m_hsp && !hs;
        vfall = m_vsp && !vs;
        h = m_pix % HT;
        v = m_pix / HT;
        was_locked = h_ok() && v_ok();
        if (hfall) push_h(h == HL - 1);
        else if (h == HL - 1) push_h(1'b0);
        advance = !hfall && (h == HT - 1);
        if (vfall) begin
            push_v(v == VL);
            m_armed = 1'b0;
        end else if (advance && v == VL && m_armed) begin
            push_v(1'b0);
        end
        if (hfall) begin
            nh = HL;
            nv = v;
        end else begin
            p  = (m_pix + 1) % FRAME;
            nh = p % HT;
            nv = p / HT;
        end
        if (vfall) nv = VL;
        else if (advance && nv == VL) m_armed = 1'b1;
        m_pix = nv * HT + nh;
        m_hsp = hs;
        m_vsp = vs;
        e = reset_exp();
        e.hpos = nh;
        e.vpos = nv;
        e.hl   = h_ok();
        e.vl   = v_ok();
        e.disp = e.hl && e.vl && (nh < HA) && (nv < VA);
        e.fs   = was_locked && (nh == 0) && (nv == 0);
    endtask

    function automatic bit h_active(input int x);
        case (line_mode)
            0:       return (x >= HS_START) && (x < HS_START + HS_WIDTH);
            1:       return (x >= HS_START - 1) && (x < HS_START + HS_WIDTH);
            2:       return 1'b0;
            default: return (x >= HS_START + 1) && (x < HS_START + HS_WIDTH);
        endcase
    endfunction

    function automatic bit v_active(input int x);
        case (frame_mode)
            0:       return (x >= VL) && (x < VL + VS_WIDTH);
            1:       return 1'b0;
            default: return (x >= VL - 1) && (x < VL - 1 + VS_WIDTH);
        endcase
    endfunction

    task automatic gen_reset();
        gh = 0; gv = 0; hs_out = 1'b1; vs_out = 1'b1;
        line_mode = 0; frame_mode = 0;
    endtask

    // Generator with registered syncs; perturbation picks odd lines/frames at random.
    task automatic gen_step(input bit perturb);
        int r;
        hs_out = !h_active(gh);
        vs_out = !v_active(gv);
        gh++;
        if (gh == HT) begin
            gh = 0;
            gv++;
            if (gv == VT) gv = 0;
        end
        if (gh == 0) begin
            r = int'($urandom_range(0, 19));
            line_mode = (perturb && r < 3) ? r + 1 : 0;
            if (gv == 0) begin
                r = int'($urandom_range(0, 5));
                frame_mode = (perturb && r < 2) ? r + 1 : 0;
            end
        end
    endtask

    // Account for the edge just passed, then drive inputs for the next period.
    task applyStimulus(input bit r_next, input bit g_next, input bit perturb, input bit chk);
        exp_t e;
        if (r_cur || r_next) begin
            model_reset();
            e = reset_exp();
        end else begin
            model_step(hsync, vsync, e);
        end
        if (g_cur || g_next) gen_reset();
        else gen_step(perturb);
        e.chk_gen = chk;
        e.gh = gh;
        e.gv = gv;
        sb.push_back(e);
        reset = r_next;
        r_cur = r_next;
        g_cur = g_next;
        hsync = (hold_low > 0) ? 1'b0 : hs_out;
        if (hold_low > 0) hold_low--;
        if (perturb && $urandom_range(0, 299) == 0) hsync = 1'b0;
        vsync = vs_out;
        @(posedge clk);
        #1;
    endtask

    task checkOutput(input exp_t e);
        n_tests++;
        if ({hpos, vpos, display_on, h_locked, v_locked, frame_start} !==
            {10'(e.hpos), 10'(e.vpos), e.disp, e.hl, e.vl, e.fs}) begin
            n_fail++;
            $display("[TB] FAIL outputs t=%0t got h=%0d v=%0d disp=%0b hl=%0b vl=%0b fs=%0b need h=%0d v=%0d disp=%0b hl=%0b vl=%0b fs=%0b",
                     $time, hpos, vpos, display_on, h_locked, v_locked, frame_start,
                     e.hpos, e.vpos, e.disp, e.hl, e.vl, e.fs);
        end
        if (e.chk_gen) begin
            n_tests++;
            if ({hpos, vpos} !== {10'(e.gh), 10'(e.gv)}) begin
                n_fail++;
                $display("[TB] FAIL gen_track t=%0t got h=%0d v=%0d need h=%0d v=%0d",
                         $time, hpos, vpos, e.gh, e.gv);
            end
        end
    endtask

    task expectLocks(input string name, input bit h, input bit v);
        n_tests++;
        if ({h_locked, v_locked} !== {h, v}) begin
            n_fail++;
            $display("[TB] FAIL %s got hl=%0b vl=%0b need hl=%0b vl=%0b",
                     name, h_locked, v_locked, h, v);
        end
    endtask

    // Monitor: compare the DUT against the oldest expectation on every falling edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (frame_start === 1'b1) fs_count++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e);
        end
    end

    int rst_left;

    initial begin
        reset = 1'b1; hsync = 1'b1; vsync = 1'b1;
        r_cur = 1'b1; g_cur = 1'b1; hold_low = 0; rst_left = 0;
        gen_reset();
        model_reset();
        @(posedge clk);
        #1;

        // Loopback with common reset: DUT must track the generator exactly.
        repeat (3) applyStimulus(1, 1, 0, 0);
        fs_count = 0;
        repeat (3 * FRAME - 10) applyStimulus(0, 0, 0, 1);
        expectLocks("loopback_lock", 1, 1);
        n_tests++;
        if (fs_count != 1) begin
            n_fail++;
            $display("[TB] FAIL frame_start_count got %0d need 1", fs_count);
        end

        // Tracker released 15 cycles after the generator.
        repeat (2) applyStimulus(1, 1, 0, 0);
        repeat (15) applyStimulus(1, 0, 0, 0);
        repeat (3 * FRAME) applyStimulus(0, 0, 0, 0);
        repeat (FRAME) applyStimulus(0, 0, 0, 1);
        expectLocks("late_release_lock", 1, 1);

        // Mid-frame reset with hsync held low across release.
        for (int i = 0; i < FRAME && !(gh == 20 && gv == 8); i++) applyStimulus(0, 0, 0, 0);
        repeat (2) applyStimulus(1, 0, 0, 0);
        hold_low = 6;
        applyStimulus(1, 0, 0, 0);
        repeat (4 * FRAME) applyStimulus(0, 0, 0, 0);
        expectLocks("relock_after_reset", 1, 1);

        // Randomised perturbation: early/late/missing syncs, glitches, resets.
        repeat (24 * FRAME) begin
            if (rst_left == 0 && $urandom_range(0, 2999) == 0) begin
                rst_left = int'($urandom_range(1, 4));
                if ($urandom_range(0, 1) == 1) hold_low = int'($urandom_range(1, 6));
            end
            applyStimulus(rst_left > 0, 0, 1, 0);
            if (rst_left > 0) rst_left--;
        end

        // Clean tail: must re-lock and re-align with the generator.
        repeat (3 * FRAME) applyStimulus(0, 0, 0, 0);
        repeat (FRAME) applyStimulus(0, 0, 0, 1);
        expectLocks("final_lock", 1, 1);

        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drain got %0d entries need 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
